// File: rtl/board_controller.sv
`default_nettype none
// ============================================================================
// Module   : board_controller
// Purpose  : Minesweeper play stage: latches the generated board, tracks
//            revealed/flagged cells and runs iterative zero-cell flood sweeps.
// Revision : 1.0 - initial release
// ============================================================================
module board_controller #(
    parameter int NUM_MINES = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         map_ready,
    input  logic [255:0] map_flat,
    input  logic [2:0]   cur_row,
    input  logic [2:0]   cur_col,
    input  logic         reveal_req,
    input  logic         flag_req,
    output logic [255:0] board,
    output logic [63:0]  revealed,
    output logic [63:0]  flagged,
    output logic [6:0]   flags_used,
    output logic [1:0]   game_state,
    output logic         busy
);

    localparam logic [2:0] S_WAIT  = 3'd0;
    localparam logic [2:0] S_PLAY  = 3'd1;
    localparam logic [2:0] S_FLOOD = 3'd2;
    localparam logic [2:0] S_LOST  = 3'd3;
    localparam logic [2:0] S_WON   = 3'd4;

    localparam logic [6:0] c_TARGET   = 7'(64 - NUM_MINES);
    localparam logic [5:0] c_LAST_IDX = 6'd63;

    // Bitmask of the in-bounds 8-neighbours of a cell, with no row/column wrap.
    function automatic logic [63:0] f_nbr_mask(input int idx);
        logic [63:0] m;
        int          r;
        int          c;
        m = '0;
        r = idx / 8;
        c = idx % 8;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                if (!(dr == 0 && dc == 0) && (r + dr) >= 0 && (r + dr) < 8 &&
                    (c + dc) >= 0 && (c + dc) < 8) begin
                    m[(r + dr) * 8 + (c + dc)] = 1'b1;
                end
            end
        end
        return m;
    endfunction

    logic [2:0]   r_state;
    logic [2:0]   w_next_state;
    logic [255:0] r_board;
    logic [63:0]  r_revealed;
    logic [63:0]  r_flagged;
    logic [6:0]   r_flags_used;
    logic [6:0]   r_rev_cnt;
    logic [5:0]   r_idx;
    logic         r_changed;

    logic [5:0]   w_k;
    logic [3:0]   w_k_val;
    logic         w_reveal_ok;
    logic         w_flag_ok;
    logic [6:0]   w_cnt_inc;
    logic [63:0]  w_mine;
    logic [63:0]  w_rz;
    logic [63:0]  w_cand;
    logic         w_flood_rev;
    logic         w_sweep_dirty;

    assign w_k         = {cur_row, cur_col};
    assign w_k_val     = r_board[{w_k, 2'b00} +: 4];
    assign w_reveal_ok = (r_state == S_PLAY) && reveal_req && !r_revealed[w_k] && !r_flagged[w_k];
    assign w_flag_ok   = (r_state == S_PLAY) && !reveal_req && flag_req && !r_revealed[w_k];
    assign w_cnt_inc   = r_rev_cnt + 7'd1;

    // Per-cell flood candidacy: hidden, unflagged, safe, touching a shown zero.
    for (genvar j = 0; j < 64; j++) begin : g_cells
        localparam logic [63:0] c_NBR = f_nbr_mask(j);
        logic [3:0] w_val;
        assign w_val     = r_board[4*j +: 4];
        assign w_mine[j] = (w_val == 4'd9);
        assign w_rz[j]   = r_revealed[j] && (w_val == 4'd0);
        assign w_cand[j] = !r_revealed[j] && !r_flagged[j] && !w_mine[j] && |(w_rz & c_NBR);
    end

    assign w_flood_rev   = w_cand[r_idx];
    assign w_sweep_dirty = r_changed | w_flood_rev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_WAIT;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (map_ready) begin
            w_next_state = S_PLAY;
        end else begin
            case (r_state)
                S_PLAY: begin
                    if (w_reveal_ok) begin
                        if (w_k_val == 4'd9)             w_next_state = S_LOST;
                        else if (w_k_val == 4'd0)        w_next_state = S_FLOOD;
                        else if (w_cnt_inc == c_TARGET)  w_next_state = S_WON;
                    end
                end
                S_FLOOD: begin
                    if (r_idx == c_LAST_IDX && !w_sweep_dirty) begin
                        w_next_state = (r_rev_cnt == c_TARGET) ? S_WON : S_PLAY;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        game_state = 2'd0;
        busy       = 1'b0;
        case (r_state)
            S_PLAY:  game_state = 2'd1;
            S_FLOOD: begin
                game_state = 2'd1;
                busy       = 1'b1;
            end
            S_LOST:  game_state = 2'd2;
            S_WON:   game_state = 2'd3;
            default: game_state = 2'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_board      <= '0;
            r_revealed   <= '0;
            r_flagged    <= '0;
            r_flags_used <= '0;
            r_rev_cnt    <= '0;
            r_idx        <= '0;
            r_changed    <= 1'b0;
        end else if (map_ready) begin
            r_board      <= map_flat;
            r_revealed   <= '0;
            r_flagged    <= '0;
            r_flags_used <= '0;
            r_rev_cnt    <= '0;
            r_idx        <= '0;
            r_changed    <= 1'b0;
        end else if (r_state == S_PLAY) begin
            if (w_reveal_ok) begin
                if (w_k_val == 4'd9) begin
                    r_revealed <= r_revealed | w_mine | (64'd1 << w_k);
                end else begin
                    r_revealed[w_k] <= 1'b1;
                    r_rev_cnt       <= w_cnt_inc;
                    r_idx           <= '0;
                    r_changed       <= 1'b0;
                end
            end else if (w_flag_ok) begin
                r_flagged[w_k] <= ~r_flagged[w_k];
                r_flags_used   <= r_flagged[w_k] ? (r_flags_used - 7'd1) : (r_flags_used + 7'd1);
            end
        end else if (r_state == S_FLOOD) begin
            if (w_flood_rev) begin
                r_revealed[r_idx] <= 1'b1;
                r_rev_cnt         <= w_cnt_inc;
            end
            // The last index both ends the sweep and rewinds for a possible next one.
            if (r_idx == c_LAST_IDX) begin
                r_idx     <= '0;
                r_changed <= 1'b0;
            end else begin
                r_idx     <= r_idx + 6'd1;
                r_changed <= w_sweep_dirty;
            end
        end
    end

    assign board      = r_board;
    assign revealed   = r_revealed;
    assign flagged    = r_flagged;
    assign flags_used = r_flags_used;

endmodule
`default_nettype wire
